adc_bcd_conv: RTL and testbench
===============================

// Module: adc_bcd_conv
// PURPOSE
//  Sequential post-processor between ADC128S102 (16-bit SPI frame) and svn_sgmnt.
//  - Averages 2**AVG_LOG2 consecutive 12-bit samples.
//  - Scales the average to millivolts.
//  - Converts the result to 4 BCD digits with a 12-iteration double-dabble.
//  - Presents the digits as a held 16-bit word for the display.
//  Runs in the clk_16M domain.
// PARAMETERS
//  AVG_LOG2  2     log2 of samples averaged per result; legal range 0..4
//  VREF_MV   3300  full-scale reference in mV; legal range 1..4096
// PORTS
//  clk_16M       in   1   system clock; all logic on rising edge
//  set_rst_flag  in   1   reset, synchronous, active-high
//  i_data        in   16  ADC frame; [11:0] = sample, [15:12] ignored
//  i_valid       in   1   one-cycle strobe, i_data valid this cycle
//  o_bcd         out  16  {thousands,hundreds,tens,ones}, one BCD nibble each
//  o_valid       out  1   one-cycle pulse; o_bcd updated this cycle
//  o_busy        out  1   high while a conversion is in flight; samples dropped
// BEHAVIOUR
//  Clock/reset: one clock, clk_16M; reset set_rst_flag is synchronous and active-high.
//  Reset state:
//  - o_bcd=16'h0000, o_valid=0, o_busy=0.
//  - FSM=ACC, accumulator=0, sample count=0, shift registers=0.
//  FSM states: ACC -> MUL -> DAB -> OUT -> ACC.
//  ACC:
//  - On i_valid: acc += i_data[11:0]; cnt += 1.
//  - acc width is 12+AVG_LOG2 bits and never overflows.
//  - When i_valid arrives with cnt == 2**AVG_LOG2-1, that sample is added and next state = MUL.
//  - With AVG_LOG2=0, every accepted sample goes straight to MUL.
//  MUL (1 cycle):
//  - avg = acc >> AVG_LOG2 (12 bits).
//  - prod = avg*VREF_MV (24 bits, unsigned).
//  - mv = prod[23:12], truncated, never rounded. mv <= 4095 for all legal params.
//  - Load bin=mv, bcd=0; next state = DAB.
//  DAB (exactly 12 cycles):
//  - Each cycle, add 3 to every bcd nibble >= 5, then shift {bcd,bin} left by 1.
//  - After 12th shift, next state = OUT.
//  OUT (1 cycle):
//  - o_bcd <= bcd; o_valid <= 1.
//  - acc and cnt cleared; next state = ACC.
//  o_valid: high for exactly one cycle per result; otherwise 0.
//  o_bcd: holds last result until next OUT. Each nibble is always 0..9.
//  o_busy = (state != ACC), decoded from the state register.
//  Latency: final sample accepted at edge N.
//  - Product registered at edge N+1.
//  - Shifts occur at edges N+2..N+13.
//  - o_bcd/o_valid update at edge N+14; o_valid clears at edge N+15.
//  Dropped samples:
//  - i_valid at edges N+1..N+14 is ignored, with no acc/cnt change.
//  - The next sample is accepted from edge N+15.
//  Simultaneous events: set_rst_flag has priority over everything, including i_valid in the same cycle.
//  Reset mid-operation:
//  - Conversion abandoned, no o_valid is emitted, o_bcd returns to 0.
//  - Partial averages are discarded.
// TESTING
//  T1 AVG_LOG2=0, VREF_MV=3300: i_data=16'h0FFF -> o_bcd=16'h3299; o_valid pulse at edge N+14; o_busy high N+1..N+14.
//  T2 AVG_LOG2=0: i_data=16'h0800 -> o_bcd=16'h1650. Then i_data=16'hF000 (top bits ignored) -> o_bcd=16'h0000.
//  T3 AVG_LOG2=2: samples 100,200,300,400 with spaced i_valid -> avg 250 -> o_bcd=16'h0201. Exactly one o_valid.
//  T4 AVG_LOG2=0: 16'h0FFF at edge N, then 16'h0000 at edge N+5 -> single o_valid with 16'h3299; 16'h0000 at N+15 -> 16'h0000.
//  T5 Reset pulse at edge N+8 mid-DAB -> no o_valid; o_bcd=0. Next 16'h0800 -> 16'h1650 with normal latency.
//  T6 VREF_MV=4096: 16'h0FFF -> 16'h4095, 16'h0001 -> 16'h0001. Back-to-back i_valid every cycle -> one result per 15 cycles.

Source files
------------

// File: rtl/adc_bcd_conv.sv
// ADC sample post-processor: averages 2**AVG_LOG2 samples, scales the average to mV,
// converts it to four BCD digits by double-dabble and holds the result for the display.
module adc_bcd_conv #(
  parameter int AVG_LOG2 = 2,
  parameter int VREF_MV  = 3300
) (
  input  logic        clk_16M,
  input  logic        set_rst_flag,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  output logic [15:0] o_bcd,
  output logic        o_valid,
  output logic        o_busy
);

  // state | meaning
  // ACC   | accumulate samples until 2**AVG_LOG2 have arrived
  // MUL   | scale the average to millivolts, seed the converter
  // DAB   | 12 double-dabble iterations
  // OUT   | publish the digits, clear the accumulator
  typedef enum logic [1:0] {
    S_ACC = 2'd0,
    S_MUL = 2'd1,
    S_DAB = 2'd2,
    S_OUT = 2'd3
  } state_t;

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [23:0]      VREF_24  = 24'(VREF_MV);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [11:0]      bin_r;
  logic [15:0]      bcd_r;
  logic [15:0]      bcd_adj;
  logic [3:0]       dab_cnt;
  logic [11:0]      avg;
  logic [23:0]      prod;
  logic [11:0]      mv;
  logic [3:0]       unused_data_hi;
  logic [11:0]      unused_prod_lo;

  // The top 12 bits of the accumulator are the average: acc >> AVG_LOG2.
  assign avg            = acc[ACC_W-1 -: 12];
  assign prod           = {12'd0, avg} * VREF_24;
  assign mv             = prod[23:12];
  assign unused_data_hi = i_data[15:12];
  assign unused_prod_lo = prod[11:0];

  always_comb begin
    bcd_adj = bcd_r;
    for (int i = 0; i < 4; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end
    end
  end

  assign o_busy = (state != S_ACC);

  always_ff @(posedge clk_16M) begin
    if (set_rst_flag) begin
      state   <= S_ACC;
      acc     <= '0;
      cnt     <= '0;
      bin_r   <= '0;
      bcd_r   <= '0;
      dab_cnt <= '0;
      o_bcd   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_ACC: begin
          if (i_valid) begin
            acc <= acc + ACC_W'(i_data[11:0]);
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          bin_r   <= mv;
          bcd_r   <= '0;
          dab_cnt <= 4'd11;
          state   <= S_DAB;
        end
        S_DAB: begin
          {bcd_r, bin_r} <= {bcd_adj[14:0], bin_r, 1'b0};
          dab_cnt        <= dab_cnt - 1'b1;
          if (dab_cnt == 4'd0) begin
            state <= S_OUT;
          end
        end
        S_OUT: begin
          o_bcd   <= bcd_r;
          o_valid <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
          state   <= S_ACC;
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_bcd_conv.sv
// Bench for adc_bcd_conv: three instances (AVG_LOG2=0/2 at 3300 mV, AVG_LOG2=0 at 4096 mV)
// checked every cycle against an arithmetic model, plus directed literal results.
module tb_adc_bcd_conv;

  localparam int LOG2 [3] = '{0, 2, 0};
  localparam int VREF [3] = '{3300, 3300, 4096};

  logic        clk = 1'b0;
  logic        rst  [3];
  logic [15:0] din  [3];
  logic        vin  [3];
  logic [15:0] bcd  [3];
  logic        ov   [3];
  logic        busy [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #31 clk = ~clk;

  adc_bcd_conv #(.AVG_LOG2(0), .VREF_MV(3300)) dut_a0 (
    .clk_16M(clk), .set_rst_flag(rst[0]), .i_data(din[0]), .i_valid(vin[0]),
    .o_bcd(bcd[0]), .o_valid(ov[0]), .o_busy(busy[0]));
  adc_bcd_conv #(.AVG_LOG2(2), .VREF_MV(3300)) dut_a2 (
    .clk_16M(clk), .set_rst_flag(rst[1]), .i_data(din[1]), .i_valid(vin[1]),
    .o_bcd(bcd[1]), .o_valid(ov[1]), .o_busy(busy[1]));
  adc_bcd_conv #(.AVG_LOG2(0), .VREF_MV(4096)) dut_v4 (
    .clk_16M(clk), .set_rst_flag(rst[2]), .i_data(din[2]), .i_valid(vin[2]),
    .o_bcd(bcd[2]), .o_valid(ov[2]), .o_busy(busy[2]));

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", nm, k, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Model: a conversion is a fixed 14-cycle busy window after the last sample is taken.
  int          m_sum  [3];
  int          m_n    [3];
  int          m_left [3];
  logic [15:0] m_bcd  [3];
  logic [15:0] m_pend [3];
  bit          m_val  [3];
  bit          m_live [3];
  int          mv_t;

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_live[k] = 0;
      m_sum[k]  = 0;
      m_n[k]    = 0;
      m_left[k] = 0;
      m_bcd[k]  = '0;
      m_pend[k] = '0;
      m_val[k]  = 0;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        m_sum[k] = 0; m_n[k] = 0; m_left[k] = 0;
        m_bcd[k] = '0; m_val[k] = 0; m_live[k] = 1;
      end else begin
        m_val[k] = 0;
        if (m_left[k] > 0) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_val[k] = 1;
            m_bcd[k] = m_pend[k];
          end
        end else if (vin[k]) begin
          m_sum[k] += int'(din[k][11:0]);
          m_n[k]++;
          if (m_n[k] == (1 << LOG2[k])) begin
            mv_t      = ((m_sum[k] >> LOG2[k]) * VREF[k]) / 4096;
            m_pend[k] = to_bcd(mv_t);
            m_left[k] = 14;
            m_sum[k]  = 0;
            m_n[k]    = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (m_live[k]) begin
        chk("bcd", k, 32'(bcd[k]), 32'(m_bcd[k]));
        chk("valid", k, 32'(ov[k]), 32'(m_val[k]));
        chk("busy", k, 32'(busy[k]), 32'(m_left[k] > 0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [15:0] d);
    din[k] = d;
    vin[k] = 1'b1;
    tick();
    vin[k] = 1'b0;
  endtask

  task automatic wait_res(input string nm, input int k, input int n0, input logic [15:0] exp);
    bit found = 0;
    for (int i = 0; i < 24 && !found; i++) begin
      tick();
      if (ov[k] === 1'b1) found = 1;
    end
    chk({nm, "_seen"}, k, 32'(found), 32'd1);
    if (found) begin
      chk({nm, "_lat"}, k, 32'(cyc - n0), 32'd14);
      chk({nm, "_bcd"}, k, 32'(bcd[k]), 32'(exp));
      chk({nm, "_idle"}, k, 32'(busy[k]), 32'd0);
    end
  endtask

  int n0, npulse, last, s;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; din[k] = '0; vin[k] = 1'b0;
    end
    tick(); tick();
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_bcd", k, 32'(bcd[k]), 32'h0);
      chk("rst_valid", k, 32'(ov[k]), 32'h0);
      chk("rst_busy", k, 32'(busy[k]), 32'h0);
    end

    // T1: full scale, busy from the acceptance edge
    send(0, 16'h0FFF); n0 = cyc;
    chk("t1_busy", 0, 32'(busy[0]), 32'd1);
    wait_res("t1", 0, n0, 16'h3299);

    // T5: reset mid-DAB abandons the conversion and clears the held digits
    send(0, 16'h0FFF); n0 = cyc;
    repeat (7) tick();
    rst[0] = 1'b1; tick(); rst[0] = 1'b0;
    chk("t5_bcd", 0, 32'(bcd[0]), 32'h0);
    chk("t5_busy", 0, 32'(busy[0]), 32'h0);
    npulse = 0;
    repeat (20) begin tick(); if (ov[0] === 1'b1) npulse++; end
    chk("t5_nopulse", 0, 32'(npulse), 32'd0);
    send(0, 16'h0800); n0 = cyc;
    wait_res("t5b", 0, n0, 16'h1650);

    // T2: mid scale, then upper frame bits ignored
    tick();
    send(0, 16'h0800); n0 = cyc;
    wait_res("t2a", 0, n0, 16'h1650);
    send(0, 16'hF000); n0 = cyc;
    wait_res("t2b", 0, n0, 16'h0000);

    // T4: sample during conversion dropped; next accepted at N+15
    send(0, 16'h0FFF); n0 = cyc;
    repeat (4) tick();
    send(0, 16'h0000);
    wait_res("t4a", 0, n0, 16'h3299);
    send(0, 16'h0000); n0 = cyc;
    chk("t4_gap", 0, 32'(busy[0]), 32'd1);
    wait_res("t4b", 0, n0, 16'h0000);

    // T3: four spaced samples averaged, then full-scale average
    send(1, 16'd100); tick(); tick();
    send(1, 16'd200); tick();
    send(1, 16'd300); tick(); tick(); tick();
    chk("t3_idle", 1, 32'(busy[1]), 32'd0);
    send(1, 16'd400); n0 = cyc;
    wait_res("t3a", 1, n0, 16'h0201);
    for (int i = 0; i < 3; i++) begin send(1, 16'h0FFF); tick(); end
    send(1, 16'h0FFF); n0 = cyc;
    wait_res("t3b", 1, n0, 16'h3299);

    // T6: VREF_MV=4096 passes the code through
    send(2, 16'h0FFF); n0 = cyc;
    wait_res("t6a", 2, n0, 16'h4095);
    send(2, 16'h0001); n0 = cyc;
    wait_res("t6b", 2, n0, 16'h0001);

    // T6: i_valid held every cycle yields one result per 15 cycles
    din[2] = 16'h0800; vin[2] = 1'b1;
    s = cyc + 1; npulse = 0; last = -1;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (ov[2] === 1'b1) begin
        npulse++;
        chk("t6c_bcd", 2, 32'(bcd[2]), 32'h2048);
        if (last >= 0) chk("t6c_gap", 2, 32'(cyc - last), 32'd15);
        else           chk("t6c_first", 2, 32'(cyc - s), 32'd14);
        last = cyc;
      end
    end
    vin[2] = 1'b0;
    repeat (20) begin tick(); if (ov[2] === 1'b1) npulse++; end
    chk("t6c_count", 2, 32'(npulse), 32'd3);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
